// File: rtl/program_loader.sv
// Boot-time program loader: streams LC2K machine words into instruction memory
// from address 0, holds the CPU idle until the image is complete, releases it,
// and stops it again on CONTROL_HALT. Images longer than MAX_WORDS are flagged.
module program_loader #(
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_WORDS  = 65536
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  CONTROL_HALT,
    output logic                  cpu_run,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  load_error
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_HALTED, S_ERROR} state_t;

    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(MAX_WORDS - 1);

    state_t             state, state_nxt;
    logic               in_ready_nxt;
    logic               cpu_run_nxt;
    logic               load_error_nxt;
    logic               clear_cnt;
    logic               xfer;
    logic [ADDR_WIDTH:0] cnt_eff;
    logic               at_last_idx;

    logic               vld_p0;
    logic [31:0]        data_p0;
    logic               last_p0;
    logic               ovf_p0;

    assign xfer        = in_valid && in_ready;
    // A word may be accepted but not yet counted; include it when checking capacity.
    assign cnt_eff     = word_count + {{ADDR_WIDTH{1'b0}}, vld_p0};
    assign at_last_idx = (cnt_eff == LAST_IDX);

    // State and registered control outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            cpu_run    <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready   <= in_ready_nxt;
            cpu_run    <= cpu_run_nxt;
            load_error <= load_error_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_nxt      = state;
        in_ready_nxt   = 1'b0;
        cpu_run_nxt    = 1'b0;
        load_error_nxt = load_error;
        clear_cnt      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt    = S_LOAD;
                    in_ready_nxt = 1'b1;
                    clear_cnt    = 1'b1;
                end
            end
            S_LOAD: begin
                // Stop accepting as soon as the terminating word is taken, so the
                // pending write is the last one before the state change.
                in_ready_nxt = in_ready && !(xfer && (in_last || at_last_idx));
                if (vld_p0 && last_p0) begin
                    state_nxt   = S_RUN;
                    cpu_run_nxt = 1'b1;
                end else if (vld_p0 && ovf_p0) begin
                    state_nxt      = S_ERROR;
                    load_error_nxt = 1'b1;
                end
            end
            S_RUN: begin
                cpu_run_nxt = !CONTROL_HALT;
                if (CONTROL_HALT) begin
                    state_nxt = S_HALTED;
                end
            end
            S_HALTED, S_ERROR: begin
                if (start) begin
                    state_nxt      = S_LOAD;
                    in_ready_nxt   = 1'b1;
                    clear_cnt      = 1'b1;
                    load_error_nxt = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Stage p0: capture the accepted word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= xfer;
        end
    end

    // Captured word payload, qualified by vld_p0
    always_ff @(posedge clk) begin
        if (xfer) begin
            data_p0 <= in_data;
            last_p0 <= in_last;
            ovf_p0  <= !in_last && at_last_idx;
        end
    end

    // Stage p1: memory write port and word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else begin
            mem_we <= vld_p0;
            if (vld_p0) begin
                mem_addr   <= word_count[ADDR_WIDTH-1:0];
                mem_wdata  <= data_p0;
                word_count <= word_count + 1'b1;
            end else if (clear_cnt) begin
                word_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: a full-size instance for the normal
// load/run/halt flows and a 4-word instance for the overflow path.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, in_valid = 1'b0, in_last = 1'b0, halt = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, mem_we, cpu_run, load_error;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [16:0] word_count;

    logic        s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_halt = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready, s_we, s_run, s_err;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata;
    logic [4:0]  s_count;

    int total = 0;
    int bad = 0;

    logic [15:0] wa [0:255];
    logic [31:0] wd [0:255];
    logic        wr [0:255];
    int          wn = 0;
    logic [3:0]  sa [0:63];
    logic [31:0] sd [0:63];
    int          sn = 0;

    always #5 clk = ~clk;

    program_loader #(.ADDR_WIDTH(16), .MAX_WORDS(65536)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .CONTROL_HALT(halt), .cpu_run(cpu_run), .word_count(word_count),
        .load_error(load_error)
    );

    program_loader #(.ADDR_WIDTH(4), .MAX_WORDS(4)) dut_small (
        .clk(clk), .reset(reset), .start(s_start), .in_valid(s_valid),
        .in_data(s_data), .in_last(s_last), .in_ready(s_ready),
        .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
        .CONTROL_HALT(s_halt), .cpu_run(s_run), .word_count(s_count),
        .load_error(s_err)
    );

    // Record every memory write, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1 && wn < 256) begin
            wa[wn] = mem_addr; wd[wn] = mem_wdata; wr[wn] = cpu_run; wn++;
        end
        if (s_we === 1'b1 && sn < 64) begin
            sa[sn] = s_addr; sd[sn] = s_wdata; sn++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input bit sel, input logic [31:0] d, input logic last, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        if (sel) begin s_valid = 1'b1; s_data = d; s_last = last; end
        else begin in_valid = 1'b1; in_data = d; in_last = last; end
        n = 0;
        while (((sel ? s_ready : in_ready) !== 1'b1) && n < 20) begin
            @(negedge clk); n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL send_ready: in_ready=0 required=1 for word %h", d);
        end
        @(negedge clk);
        if (sel) begin s_valid = 1'b0; s_data = '0; s_last = 1'b0; end
        else begin in_valid = 1'b0; in_data = '0; in_last = 1'b0; end
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) s_start = 1'b1; else start = 1'b1;
        @(negedge clk);
        s_start = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, mem_we, cpu_run, load_error} !== 4'b0000 || mem_addr !== 16'h0 ||
            mem_wdata !== 32'h0 || word_count !== 17'h0) begin
            bad++;
            $display("FAIL reset_values: rdy=%b we=%b run=%b err=%b addr=%h wdata=%h cnt=%0d required all zero",
                     in_ready, mem_we, cpu_run, load_error, mem_addr, mem_wdata, word_count);
        end
        total++;
        if ({s_ready, s_we, s_run, s_err} !== 4'b0000 || s_count !== 5'h0) begin
            bad++;
            $display("FAIL reset_small: rdy=%b we=%b run=%b err=%b cnt=%0d required zero",
                     s_ready, s_we, s_run, s_err, s_count);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_load;
        int base;
        @(posedge clk); base = wn; @(negedge clk);
        pulse_start(0);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: in_ready=%b required=1", in_ready); end
        for (int i = 0; i < 5; i++) send(0, 32'h00810007 + i, i == 4, 0);
        repeat (2) @(negedge clk);
        total++;
        if (wn - base !== 5) begin bad++; $display("FAIL basic_nwrites: got=%0d required=5", wn - base); end
        for (int i = 0; i < 5 && base + i < wn; i++) begin
            total++;
            if (wa[base+i] !== 16'(i) || wd[base+i] !== 32'h00810007 + i || wr[base+i] !== (i == 4)) begin
                bad++;
                $display("FAIL basic_write%0d: addr=%h data=%h run=%b required addr=%h data=%h run=%b",
                         i, wa[base+i], wd[base+i], wr[base+i], 16'(i), 32'h00810007 + i, (i == 4));
            end
        end
        total++;
        if (word_count !== 17'd5 || cpu_run !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_final: cnt=%0d run=%b rdy=%b required cnt=5 run=1 rdy=0", word_count, cpu_run, in_ready);
        end
    endtask

    task automatic test_halt_reload;
        int base;
        halt = 1'b1; @(negedge clk); halt = 1'b0;
        total++;
        if (cpu_run !== 1'b0 || word_count !== 17'd5) begin
            bad++;
            $display("FAIL halt_stop: run=%b cnt=%0d required run=0 cnt=5", cpu_run, word_count);
        end
        @(posedge clk); base = wn; @(negedge clk);
        pulse_start(0);
        total++;
        if (word_count !== 17'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reload_clear: cnt=%0d rdy=%b required cnt=0 rdy=1", word_count, in_ready);
        end
        for (int i = 0; i < 3; i++) send(0, 32'hA0000000 + i, i == 2, 0);
        repeat (2) @(negedge clk);
        total++;
        if (word_count !== 17'd3 || cpu_run !== 1'b1 || wn - base !== 3) begin
            bad++;
            $display("FAIL reload_final: cnt=%0d run=%b writes=%0d required cnt=3 run=1 writes=3", word_count, cpu_run, wn - base);
        end
        for (int i = 0; i < 3 && base + i < wn; i++) begin
            total++;
            if (wa[base+i] !== 16'(i) || wd[base+i] !== 32'hA0000000 + i) begin
                bad++;
                $display("FAIL reload_write%0d: addr=%h data=%h required addr=%h data=%h",
                         i, wa[base+i], wd[base+i], 16'(i), 32'hA0000000 + i);
            end
        end
    endtask

    task automatic test_random_valid;
        int base;
        halt = 1'b1; @(negedge clk); halt = 1'b0;
        @(posedge clk); base = wn; @(negedge clk);
        pulse_start(0);
        for (int i = 0; i < 8; i++) send(0, 32'h5EED0000 + i * 3, i == 7, $urandom_range(0, 2));
        repeat (2) @(negedge clk);
        total++;
        if (wn - base !== 8 || word_count !== 17'd8) begin
            bad++;
            $display("FAIL random_count: writes=%0d cnt=%0d required 8", wn - base, word_count);
        end
        for (int i = 0; i < 8 && base + i < wn; i++) begin
            total++;
            if (wa[base+i] !== 16'(i) || wd[base+i] !== 32'h5EED0000 + i * 3) begin
                bad++;
                $display("FAIL random_write%0d: addr=%h data=%h required addr=%h data=%h",
                         i, wa[base+i], wd[base+i], 16'(i), 32'h5EED0000 + i * 3);
            end
        end
    endtask

    task automatic test_start_ignored;
        halt = 1'b1; @(negedge clk); halt = 1'b0;
        pulse_start(0);
        send(0, 32'h11111111, 1'b0, 0);
        send(0, 32'h22222222, 1'b0, 0);
        pulse_start(0);
        @(negedge clk);
        total++;
        if (word_count !== 17'd2 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL start_in_load: cnt=%0d rdy=%b required cnt=2 rdy=1", word_count, in_ready);
        end
        send(0, 32'h33333333, 1'b1, 0);
        @(negedge clk);
        pulse_start(0);
        @(negedge clk);
        total++;
        if (word_count !== 17'd3 || cpu_run !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL start_in_run: cnt=%0d run=%b rdy=%b required cnt=3 run=1 rdy=0", word_count, cpu_run, in_ready);
        end
        start = 1'b1; halt = 1'b1; @(negedge clk); start = 1'b0; halt = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_run !== 1'b0 || in_ready !== 1'b0 || word_count !== 17'd3) begin
            bad++;
            $display("FAIL start_with_halt: run=%b rdy=%b cnt=%0d required run=0 rdy=0 cnt=3", cpu_run, in_ready, word_count);
        end
    endtask

    task automatic test_overflow;
        int base;
        @(posedge clk); base = sn; @(negedge clk);
        pulse_start(1);
        for (int i = 0; i < 4; i++) send(1, 32'hC0DE0000 + i, 1'b0, 0);
        repeat (2) @(negedge clk);
        total++;
        if (sn - base !== 4) begin bad++; $display("FAIL ovf_nwrites: got=%0d required=4", sn - base); end
        for (int i = 0; i < 4 && base + i < sn; i++) begin
            total++;
            if (sa[base+i] !== 4'(i) || sd[base+i] !== 32'hC0DE0000 + i) begin
                bad++;
                $display("FAIL ovf_write%0d: addr=%h data=%h required addr=%h data=%h",
                         i, sa[base+i], sd[base+i], 4'(i), 32'hC0DE0000 + i);
            end
        end
        total++;
        if (s_err !== 1'b1 || s_ready !== 1'b0 || s_run !== 1'b0 || s_count !== 5'd4) begin
            bad++;
            $display("FAIL ovf_state: err=%b rdy=%b run=%b cnt=%0d required err=1 rdy=0 run=0 cnt=4", s_err, s_ready, s_run, s_count);
        end
        pulse_start(1);
        total++;
        if (s_err !== 1'b0 || s_ready !== 1'b1 || s_count !== 5'd0) begin
            bad++;
            $display("FAIL ovf_restart: err=%b rdy=%b cnt=%0d required err=0 rdy=1 cnt=0", s_err, s_ready, s_count);
        end
    endtask

    task automatic test_reset_midload;
        int base;
        pulse_start(0);
        send(0, 32'hDEAD0001, 1'b0, 0);
        send(0, 32'hDEAD0002, 1'b0, 0);
        reset = 1'b1;
        #1;
        total++;
        if ({in_ready, mem_we, cpu_run, load_error} !== 4'b0000 || mem_addr !== 16'h0 ||
            mem_wdata !== 32'h0 || word_count !== 17'h0) begin
            bad++;
            $display("FAIL async_reset: rdy=%b we=%b run=%b err=%b addr=%h wdata=%h cnt=%0d required all zero",
                     in_ready, mem_we, cpu_run, load_error, mem_addr, mem_wdata, word_count);
        end
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0 || word_count !== 17'd0) begin
            bad++;
            $display("FAIL reset_idle: rdy=%b cnt=%0d required rdy=0 cnt=0", in_ready, word_count);
        end
        @(posedge clk); base = wn; @(negedge clk);
        pulse_start(0);
        send(0, 32'hBEEF0000, 1'b0, 0);
        send(0, 32'hBEEF0001, 1'b1, 0);
        repeat (2) @(negedge clk);
        total++;
        if (wn - base !== 2 || word_count !== 17'd2 || cpu_run !== 1'b1) begin
            bad++;
            $display("FAIL reset_reload: writes=%0d cnt=%0d run=%b required writes=2 cnt=2 run=1", wn - base, word_count, cpu_run);
        end
        for (int i = 0; i < 2 && base + i < wn; i++) begin
            total++;
            if (wa[base+i] !== 16'(i) || wd[base+i] !== 32'hBEEF0000 + i) begin
                bad++;
                $display("FAIL reset_reload_write%0d: addr=%h data=%h required addr=%h data=%h",
                         i, wa[base+i], wd[base+i], 16'(i), 32'hBEEF0000 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_halt_reload();
        test_random_valid();
        test_start_ignored();
        test_overflow();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
